// File: rtl/cpu_isa_pkg.sv
// cpu_isa_pkg: shared ISA constants, decoded-instruction record and field decode helpers
package cpu_isa_pkg;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;
    localparam int NREGS   = 1 << RADDR_W;

    localparam int OPC_HI   = 31;
    localparam int OPC_LO   = 26;
    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 11;
    localparam int IMM_HI   = 15;
    localparam int IMM_LO   = 0;
    localparam int FUNCT_HI = 5;
    localparam int FUNCT_LO = 0;
    localparam int IMM_W    = IMM_HI - IMM_LO + 1;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    typedef struct packed {
        logic [5:0]         opcode;
        logic [5:0]         funct;
        logic [RADDR_W-1:0] rs;
        logic [RADDR_W-1:0] rt;
        logic [RADDR_W-1:0] wr_addr;
        logic               wr_en;
        logic [XLEN-1:0]    imm;
    } decoded_t;

    // R-type, stores and branches compare/consume rt; other I-types only read rs
    function automatic logic uses_rt(input logic [5:0] op);
        return op == OP_RTYPE || op == OP_SW || op == OP_BEQ;
    endfunction

    // Non-writing opcodes report wr_addr 0 so the scoreboard never sees a stale destination
    function automatic decoded_t decode(input logic [XLEN-1:0] instr);
        decoded_t d;
        logic     i_wr;
        logic     zext;
        d.opcode  = instr[OPC_HI:OPC_LO];
        d.funct   = instr[FUNCT_HI:FUNCT_LO];
        d.rs      = instr[RS_HI:RS_LO];
        d.rt      = instr[RT_HI:RT_LO];
        i_wr      = d.opcode inside {OP_ADDI, OP_ANDI, OP_ORI, OP_LW};
        zext      = d.opcode inside {OP_ANDI, OP_ORI};
        d.wr_addr = (d.opcode == OP_RTYPE) ? instr[RD_HI:RD_LO] : (i_wr ? d.rt : '0);
        d.wr_en   = (d.opcode == OP_RTYPE || i_wr) && d.wr_addr != '0;
        d.imm     = (d.opcode == OP_RTYPE) ? '0 :
                    zext ? {{(XLEN-IMM_W){1'b0}}, instr[IMM_HI:IMM_LO]} :
                           {{(XLEN-IMM_W){instr[IMM_HI]}}, instr[IMM_HI:IMM_LO]};
        return d;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register busy bits for in-flight writes and RAW/WAW hazard detection
module reg_scoreboard
    import cpu_isa_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               set_en_i,
    input  logic [RADDR_W-1:0] set_addr_i,
    input  logic               clr_en_i,
    input  logic [RADDR_W-1:0] clr_addr_i,
    input  logic               flush_en_i,
    input  logic [RADDR_W-1:0] flush_addr_i,
    input  logic [RADDR_W-1:0] rs_i,
    input  logic [RADDR_W-1:0] rt_i,
    input  logic               rt_used_i,
    input  logic [RADDR_W-1:0] dest_i,
    input  logic               dest_used_i,
    output logic               hazard_o
);

    logic [NREGS-1:0] busy_d, busy_q;

    // r0 is never busy, so lookups of r0 can never raise a hazard
    assign hazard_o = busy_q[rs_i] || (rt_used_i && busy_q[rt_i]) || (dest_used_i && busy_q[dest_i]);

    // clears applied first so a same-cycle set on the same register wins
    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) busy_d[clr_addr_i] = 1'b0;
        if (flush_en_i) busy_d[flush_addr_i] = 1'b0;
        if (set_en_i) busy_d[set_addr_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // busy state register
    always_ff @(posedge clk) begin
        if (reset) busy_q <= '0;
        else       busy_q <= busy_d;
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: splits instructions into fields, stalls on scoreboard hazards, holds result for execute
module decode_stage
    import cpu_isa_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [5:0]         out_opcode,
    output logic [5:0]         out_funct,
    output logic [RADDR_W-1:0] out_rs,
    output logic [RADDR_W-1:0] out_rt,
    output logic [RADDR_W-1:0] out_wr_addr,
    output logic               out_wr_en,
    output logic [XLEN-1:0]    out_imm,
    input  logic               wb_valid,
    input  logic [RADDR_W-1:0] wb_addr,
    input  logic               flush,
    output logic [15:0]        stall_cnt
);

    decoded_t    dec_in, dec_d, dec_q;
    logic        out_valid_d, out_valid_q;
    logic [15:0] stall_cnt_d, stall_cnt_q;
    logic        hazard, accept, rt_used;

    assign dec_in   = decode(in_instr);
    assign rt_used  = uses_rt(dec_in.opcode);
    assign in_ready = !reset && (!out_valid_q || out_ready) && !hazard && !flush;
    assign accept   = in_valid && in_ready;

    reg_scoreboard u_sb (
        .clk          (clk),
        .reset        (reset),
        .set_en_i     (accept && dec_in.wr_en),
        .set_addr_i   (dec_in.wr_addr),
        .clr_en_i     (wb_valid),
        .clr_addr_i   (wb_addr),
        .flush_en_i   (flush && out_valid_q && dec_q.wr_en),
        .flush_addr_i (dec_q.wr_addr),
        .rs_i         (dec_in.rs),
        .rt_i         (dec_in.rt),
        .rt_used_i    (rt_used),
        .dest_i       (dec_in.wr_addr),
        .dest_used_i  (dec_in.wr_en),
        .hazard_o     (hazard)
    );

    // fields load only on accept, so they stay frozen under backpressure and after drain
    always_comb begin
        dec_d       = accept ? dec_in : dec_q;
        out_valid_d = accept || (out_valid_q && !out_ready && !flush);
        stall_cnt_d = (in_valid && hazard && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
    end

    // output register and stall counter
    always_ff @(posedge clk) begin
        if (reset) begin
            dec_q       <= '0;
            out_valid_q <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            dec_q       <= dec_d;
            out_valid_q <= out_valid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_opcode  = dec_q.opcode;
    assign out_funct   = dec_q.funct;
    assign out_rs      = dec_q.rs;
    assign out_rt      = dec_q.rt;
    assign out_wr_addr = dec_q.wr_addr;
    assign out_wr_en   = dec_q.wr_en;
    assign out_imm     = dec_q.imm;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction decode stage sitting directly upstream of the 32×32 register file. It accepts one 32-bit instruction per cycle over a valid/ready handshake, splits it into fields, and drives the register file read addresses. It sign/zero-extends the immediate and tracks pending register writes in a scoreboard, stalling on RAW/WAW hazards until write-back clears them. Its output register is consumed by the execute stage together with the register file read data.

## Interface

- `XLEN`, 32, instruction/immediate width (fixed; other values unsupported)
- `RADDR_W`, 5, register address width
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `in_valid`  in  1  fetch presents an instruction
- `in_ready`  out  1  decode accepts this cycle
- `in_instr`  in  32  instruction word
- `out_valid`  out  1  decoded instruction held in output register
- `out_ready`  in  1  execute consumes this cycle
- `out_opcode`  out  6  instr[31:26]
- `out_funct`  out  6  instr[5:0]
- `out_rs`, `out_rt`  out  5  instr[25:21], instr[20:16]; also drive register file read addresses 1/2
- `out_wr_addr`  out  5  destination register (rd for R-type, rt for I-type writers)
- `out_wr_en`  out  1  instruction writes a register (0 if dest = r0)
- `out_imm`  out  32  extended immediate
- `wb_valid`  in  1  write-back completes
- `wb_addr`  in  5  register written back; clears its busy bit
- `flush`  in  1  squash held instruction
- `stall_cnt`  out  16  saturating count of hazard-stall cycles

## Operation

- Formats: opcode 0x00 is R-type and writes rd = instr[15:11]. Opcodes 0x08, 0x0C, 0x0D, 0x23 (addi, andi, ori, lw) write rt. Opcodes 0x2B and 0x04 (sw, beq) write nothing. All other opcodes: wr_en = 0, passed through.
- Immediate: andi/ori zero-extend instr[15:0]; all others sign-extend. R-type imm = 0.
- Scoreboard: 32 busy bits; r0 never set.
- Hazard when the incoming instruction's rs or rt (nonzero, if used) is busy, or when its destination is busy (WAW).
- Source usage: R-type, beq and sw use rs and rt; other I-types use rs only.
- `in_ready` = (!out_valid | out_ready) & !hazard & !flush.
- Accept (in_valid & in_ready): load all out_* fields, set out_valid, set busy[dest] if out_wr_en.
- Output drained without a new accept: out_valid ← 0.
- wb_valid clears busy[wb_addr]. If the same register is set by an accept in the same cycle, set wins.
- flush: out_valid ← 0 and clears the busy bit the held instruction had set. If the flushed instruction's dest equals wb_addr in that cycle, the bit ends clear. No accept that cycle.
- stall_cnt increments each cycle with in_valid & hazard and saturates at 0xFFFF.

## Timing

- Decode latency: 1 cycle from accept to out_valid.
- Hazard check uses registered busy bits; no write-back bypass. A cleared source becomes acceptable the cycle after wb_valid.
- `out_rs`/`out_rt` are stable for the whole out_valid period. The register file reads on the falling edge, so its data is valid at the next rising edge alongside the out_* fields.
- Back-to-back throughput: 1 instruction/cycle with out_ready held high and no hazards.
- Reset (any cycle, including mid-stall): out_valid = 0, all out_* fields = 0, busy = 0, stall_cnt = 0, in_ready = 0 during the reset cycle.
- Fields are held unchanged while out_valid & !out_ready.

## Structure

- Shared package `cpu_isa_pkg`:
  - opcode constants (OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW, OP_BEQ)
  - field bit positions
  - XLEN/RADDR_W constants
- Sub-module `reg_scoreboard`: 32 busy bits with set port, clear port and flush-clear port; two source lookups plus one destination lookup, giving the hazard output.

## Test plan

- Reset, then `add r3,r1,r2` (0x00221820) with out_ready=1:
  - next cycle out_valid=1, rs=1, rt=2, wr_addr=3, wr_en=1, funct=0x20;
  - busy[3]=1.
- RAW stall, then `lw r5,4(r3)` (0x8C650004):
  - in_ready=0 and stall_cnt increments each cycle;
  - assert wb_valid/wb_addr=3, and the lw is accepted the following cycle with imm=0x00000004 and wr_addr=5.
- `ori r4,r0,0x8000` (0x34048000):
  - imm=0x00008000;
  - `addi r4,r0,-1` gives imm=0xFFFFFFFF;
  - the second stalls on WAW (r4 busy) until wb r4.
- Backpressure: out_ready=0 with 3 queued independent instructions:
  - in_ready=0 and outputs stay frozen;
  - when out_ready rises, one instruction issues per cycle.
- Flush a held `add r7,r1,r2`:
  - out_valid=0 and busy[7]=0 next cycle;
  - a following instruction reading r7 is accepted immediately.
- Reset asserted during a stall:
  - all outputs zero, scoreboard clear, stall_cnt=0;
  - the first instruction after reset is accepted.
